// File: rtl/fpu_pkg.sv
// Shared FP encodings and the pipeline stage record used by the FMA issue/writeback controller.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    // Wide enough for any register file up to 256 entries; narrower specifiers are zero-extended.
    localparam int unsigned RD_W = 8;

    typedef struct packed {
        logic            vld;
        logic [RD_W-1:0] rd;
    } stage_t;

    // Returns {rp, rm, rz, rn}.
    function automatic logic [3:0] rm_onehot(input logic [2:0] mode);
        case (mode)
            RM_RTZ:  return 4'b0010;
            RM_RDN:  return 4'b0100;
            RM_RUP:  return 4'b1000;
            default: return 4'b0001;
        endcase
    endfunction

    // A dynamic mode whose CSR value is itself DYN is just as unusable as 5 or 6.
    function automatic logic rm_reserved(input logic [2:0] mode);
        return mode > RM_RMM;
    endfunction

endpackage

// File: rtl/fma_hazard_unit.sv
// Compares the incoming source specifiers against the ops in E and W and picks
// bypass, register forwarding or a one-cycle stall.
module fma_hazard_unit
    import fpu_pkg::*;
#(
    parameter int unsigned RW = 5
) (
    input  logic          issue_valid,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rs3,
    input  stage_t        e,
    input  stage_t        w,
    output logic [1:0]    bypsel_next,
    output logic [2:0]    fwd_sel,
    output logic          stall
);

    logic [2:0] e_hit;
    logic [2:0] w_hit;

    always_comb begin
        e_hit[0] = e.vld && (RD_W'(rs1) == e.rd);
        e_hit[1] = e.vld && (RD_W'(rs2) == e.rd);
        e_hit[2] = e.vld && (RD_W'(rs3) == e.rd);
        w_hit[0] = w.vld && (RD_W'(rs1) == w.rd);
        w_hit[1] = w.vld && (RD_W'(rs2) == w.rd);
        w_hit[2] = w.vld && (RD_W'(rs3) == w.rd);
    end

    // The youngest producer wins; Y has no bypass path so an E hit on rs2 must wait for W.
    assign bypsel_next = {e_hit[2], e_hit[0]};
    assign fwd_sel     = w_hit & ~e_hit;
    assign stall       = issue_valid && e_hit[1];

endmodule

// File: rtl/fma_issue_ctrl.sv
// Operand issue and writeback control around the FMAC: registers operands for E,
// captures the result in W and keeps the sticky IEEE flags.
module fma_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned XLEN  = 64,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic [RW-1:0]   rs3,
    input  logic [RW-1:0]   rd,
    input  logic [2:0]      frm_instr,
    input  logic [2:0]      frm_csr,
    input  logic [XLEN-1:0] xrf_rd,
    input  logic [XLEN-1:0] yrf_rd,
    input  logic [XLEN-1:0] zrf_rd,
    output logic [XLEN-1:0] xrf,
    output logic [XLEN-1:0] y,
    output logic [XLEN-1:0] zrf,
    output logic            rn,
    output logic            rz,
    output logic            rm,
    output logic            rp,
    output logic [1:0]      bypsel,
    output logic            bypplus1,
    output logic            byppostnorm,
    input  logic            rnd_inc,
    input  logic            rnd_postnorm,
    input  logic [XLEN-1:0] w,
    input  logic            invalid,
    input  logic            overflow,
    input  logic            underflow,
    input  logic            inexact,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      fflags,
    input  logic            fflags_clr,
    output logic            illegal_rm
);

    stage_t     e_q;
    stage_t     w_q;
    logic [4:0] w_flags_q;
    logic [4:0] e_flags;
    logic [2:0] eff_rm;
    logic       bad_rm;
    logic       accept;
    logic       issue;
    logic [1:0] bypsel_next;
    logic [2:0] fwd_sel;
    logic       stall;

    fma_hazard_unit #(
        .RW(RW)
    ) u_hazard (
        .issue_valid(issue_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs3        (rs3),
        .e          (e_q),
        .w          (w_q),
        .bypsel_next(bypsel_next),
        .fwd_sel    (fwd_sel),
        .stall      (stall)
    );

    always_comb begin
        e_flags          = '0;
        e_flags[FLAG_NV] = invalid;
        e_flags[FLAG_OF] = overflow;
        e_flags[FLAG_UF] = underflow;
        e_flags[FLAG_NX] = inexact;
    end

    assign eff_rm      = (frm_instr == RM_DYN) ? frm_csr : frm_instr;
    assign bad_rm      = rm_reserved(eff_rm);
    assign issue_ready = !stall;
    assign accept      = issue_valid && !stall;
    // Reserved-mode ops complete the handshake but never enter E.
    assign issue       = accept && !bad_rm;
    assign wb_valid    = w_q.vld;
    assign wb_rd       = w_q.rd[RW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q                  <= '0;
            w_q                  <= '0;
            w_flags_q            <= '0;
            xrf                  <= '0;
            y                    <= '0;
            zrf                  <= '0;
            {rp, rm, rz, rn}     <= '0;
            bypsel               <= '0;
            bypplus1             <= 1'b0;
            byppostnorm          <= 1'b0;
            wb_data              <= '0;
            fflags               <= '0;
            illegal_rm           <= 1'b0;
        end else begin
            e_q.vld <= issue;
            if (issue) begin
                e_q.rd           <= RD_W'(rd);
                xrf              <= fwd_sel[0] ? wb_data : xrf_rd;
                y                <= fwd_sel[1] ? wb_data : yrf_rd;
                zrf              <= fwd_sel[2] ? wb_data : zrf_rd;
                {rp, rm, rz, rn} <= rm_onehot(eff_rm);
            end
            bypsel      <= issue ? bypsel_next : 2'b00;
            // rnd_inc/rnd_postnorm belong to the producer now in E, which is in W next cycle.
            bypplus1    <= issue && bypsel_next[0] && rnd_inc;
            byppostnorm <= issue && bypsel_next[1] && rnd_postnorm;
            illegal_rm  <= accept && bad_rm;

            w_q <= e_q;
            if (e_q.vld) begin
                wb_data   <= w;
                w_flags_q <= e_flags;
            end
            fflags <= (fflags_clr ? 5'b0 : fflags) | (w_q.vld ? w_flags_q : 5'b0);
        end
    end

endmodule

// File: doc/fma_issue_ctrl.md
Name: fma_issue_ctrl

Overview:
- Operand-issue and writeback controller directly upstream and downstream of the FMAC datapath.
- Accepts FMA ops from decode through a valid/ready handshake and registers operands into the FMAC.
- Drives rounding-mode one-hots and the W→X / W→Z bypass controls, and detects RAW hazards.
- Captures the FMAC result into a writeback register and accumulates sticky IEEE flags.

Parameters:
- NREGS, 32, number of FP architectural registers; register specifiers are clog2(NREGS) bits wide (RW).
- XLEN, 64, operand/result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an op
- issue_ready  out  1  op accepted this cycle when valid&ready
- rs1, rs2, rs3, rd  in  RW  source X, Y, Z and destination specifiers
- frm_instr  in  3  instruction rounding mode; 7 = dynamic
- frm_csr  in  3  CSR rounding mode
- xrf_rd, yrf_rd, zrf_rd  in  XLEN  register-file read data
- xrf, y, zrf  out  XLEN  registered FMAC operands
- rn, rz, rm, rp  out  1  one-hot rounding mode to FMAC
- bypsel  out  2  [0] selects W→X, [1] selects W→Z
- bypplus1, byppostnorm  out  1  bypass rounding-fixup controls
- rnd_inc, rnd_postnorm  in  1  rounding increment / mantissa-overflow of the op in E
- w  in  XLEN  FMAC result
- invalid, overflow, underflow, inexact  in  1  FMAC flags
- wb_valid  out  1  result retires this cycle
- wb_rd  out  RW  destination of retiring op
- wb_data  out  XLEN  retiring result
- fflags  out  5  sticky {NV,DZ,OF,UF,NX}
- fflags_clr  in  1  clear fflags
- illegal_rm  out  1  pulse: op rejected for reserved rounding mode

Behaviour:
- Reset: all outputs 0; E and W stages empty; fflags = 0. Reset mid-operation discards in-flight ops with no writeback.
- Pipeline: 2 stages.
  - E: operand registers feed FMAC; FMAC evaluates combinationally.
  - W: captures w and flags.
  - Issue→wb_valid latency is 2 cycles without a stall.
- Stage state: e_vld, e_rd, w_vld, w_rd. E advances to W every cycle; no downstream backpressure.
- Rounding mode: effective mode = frm_csr if frm_instr = 7, else frm_instr. Encoding: 0 RNE→rn, 1 RTZ→rz, 2 RDN→rm, 3 RUP→rp, 4 RMM→rn.
  - Effective mode 5 or 6: op accepted but not issued, illegal_rm pulses 1 cycle, and no writeback occurs.
- Hazard against E (op issued in the previous cycle):
  - rs1 == e_rd: bypsel[0] = 1 in the new op's E cycle.
  - rs3 == e_rd: bypsel[1] = 1 in the new op's E cycle.
  - rs2 == e_rd: no Y bypass path exists. issue_ready = 0 for one cycle; the op issues next cycle with forwarding from W.
- Hazard against W (only applies when there is no E match):
  - Any rs matching w_rd is muxed from wb_data into the operand register, because the RF write is not yet visible.
  - If both E and W match, E (youngest) wins.
- bypplus1 and byppostnorm are registered copies of rnd_inc and rnd_postnorm, valid only in cycles where the corresponding bypsel bit is set; otherwise 0.
- issue_ready = !(stall). A stall holds all operand registers; e_vld = 0 is inserted as a bubble.
- Writeback:
  - wb_valid = w_vld; wb_data = registered w.
  - fflags |= {invalid, 0, overflow, underflow, inexact} on each retiring op.
  - fflags_clr together with a retiring op: the result is the new op's flags only (clear first, then OR).
- Specifier matches are ignored when the matching stage is invalid.

Decomposition:
- Package fpu_pkg:
  - rounding-mode encodings RNE..RMM and DYN;
  - fflags bit indices;
  - typedef of the stage record {vld, rd}.
- One sub-module, fma_hazard_unit: combinational compare of rs1/rs2/rs3 against the E and W records. Produces bypsel_next, fwd_sel[2:0], stall.

Test Plan:
- Independent back-to-back ops (rd = 1, then rd = 2, sources 3/4/5), frm = 0 → rn = 1, bypsel = 00, wb_valid on cycles 2 and 3, no stall.
- Op A rd = 4, then op B rs1 = 4, rs3 = 4 → bypsel = 11 in B's E cycle; with rnd_inc = 1, bypplus1 = 1; issue_ready stays 1.
- Op A rd = 4, then op B rs2 = 4 → issue_ready = 0 for exactly 1 cycle; B's y equals A's wb_data; B retires 1 cycle later than unstalled.
- frm_instr = 7 with frm_csr = 2 → rm = 1 only. frm_instr = 5 → illegal_rm pulse, no wb_valid for that op.
- Two ops retiring with inexact = 1 then overflow = 1 → fflags = 5'b00101; fflags_clr asserted while the second retires → fflags = 5'b00100.
- Reset asserted with E and W both valid → next cycle wb_valid = 0, fflags = 0, issue_ready = 1.
